// File: rtl/if_fetch_queue_pkg.sv
// Shared constants for the fetch queue: the bubble instruction and the zero word.
package if_fetch_queue_pkg;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bundle: ROM/predictor/redirect inputs on one side, queue head toward decode on the other.
interface if_fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] rom_addr;
    logic [XLEN-1:0] instr_i;
    logic            pred_taken_i;
    logic [XLEN-1:0] pred_target_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            ready_i;
    logic            valid_o;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] pc_o;
    logic            pred_taken_o;
    logic [CW-1:0]   count_o;
    logic            full_o;

    modport master (
        output rom_addr, valid_o, instr_o, pc_o, pred_taken_o, count_o, full_o,
        input  instr_i, pred_taken_i, pred_target_i, redirect_i, redirect_pc_i, ready_i
    );

    modport slave (
        input  rom_addr, valid_o, instr_o, pc_o, pred_taken_o, count_o, full_o,
        output instr_i, pred_taken_i, pred_target_i, redirect_i, redirect_pc_i, ready_i
    );

endinterface

// File: rtl/if_fetch_queue_fifo.sv
// DEPTH-entry ring buffer with occupancy count; clr empties it on the next edge.
module if_fetch_queue_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 65,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic                    do_wr, do_rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_en && !full && !clr;
    assign do_rd = rd_en && !empty && !clr;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; count gates every read of it.
    always_ff @(posedge clk)
        if (do_wr) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PW'(1);
            if (do_rd) rd_ptr <= rd_ptr + PW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage with instruction queue: owns the PC, drives the ROM address, buffers fetched words for decode.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_WORD)
) (
    input logic              clk,
    input logic              rst_n,
    if_fetch_queue_if.master fq
);
    localparam int              EW      = 2*XLEN + 1;
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] PC_INIT = {RESET_PC[XLEN-1:2], 2'b00};

    logic [XLEN-1:0] pc, pc_nxt;
    logic            enq, deq, full, empty;
    logic [EW-1:0]   head;
    logic [CW-1:0]   count;

    // Gating uses registered full only, so ready_i never reaches rom_addr.
    assign enq = !full && !fq.redirect_i;
    assign deq = !empty && fq.ready_i && !fq.redirect_i;

    always_comb begin
        pc_nxt = pc;
        if (fq.redirect_i)                pc_nxt = fq.redirect_pc_i;
        else if (enq && fq.pred_taken_i)  pc_nxt = fq.pred_target_i;
        else if (enq)                     pc_nxt = pc + XLEN'(4);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pc <= PC_INIT;
        else        pc <= {pc_nxt[XLEN-1:2], 2'b00};

    if_fetch_queue_fifo #(.DEPTH(DEPTH), .W(EW), .CW(CW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (fq.redirect_i),
        .wr_en   (enq),
        .wr_data ({fq.instr_i, pc, fq.pred_taken_i}),
        .rd_en   (deq),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign fq.rom_addr     = pc;
    assign fq.valid_o      = !empty;
    assign fq.instr_o      = empty ? NOP_INSTR       : head[EW-1 -: XLEN];
    assign fq.pc_o         = empty ? XLEN'(ZERO_WORD) : head[XLEN:1];
    assign fq.pred_taken_o = !empty && head[0];
    assign fq.count_o      = count;
    assign fq.full_o       = full;

endmodule
